semaforo_ctrl: RTL and testbench

//  Parametrised two-road traffic-light controller with pedestrian signals. Successor of the fixed 4-state controller:
//  - programmable phase durations
//  - all-red clearance phases
//  - latched pedestrian push-buttons that shorten the opposing green
//  - night mode with flashing yellow

---
 rtl/semaforo_ctrl.sv | 153 +++++++++++++++
 tb/tb_semaforo_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_ctrl.sv
// Two-road traffic-light controller: G/Y/all-red cycle, latched pedestrian cut, night flashing.
// Latency: lamps are a pure decode of registered state; a push-button shortens green 1 cycle after sampling.
// Backpressure: none; free-running, inputs are sampled every rising edge of clk.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (state R2, counters and latches cleared)
//   night     level request for night (flashing yellow) mode, honoured at all-red only
//   ped_req1  push-button for the crossing parallel to road 1
//   ped_req2  push-button for the crossing parallel to road 2
//   c1, c2    lamp codes for road 1 / road 2 (0 green, 1 yellow, 2 red, 3 off)
//   p1, p2    pedestrian walk lamps, parallel to road 1 / road 2
//   wait1/2   pending pedestrian request indicators
module semaforo_ctrl #(
  parameter int CW          = 8,
  parameter int T_GREEN     = 8,
  parameter int T_MIN_GREEN = 3,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_FLASH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       night,
  input  logic       ped_req1,
  input  logic       ped_req2,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic       p1,
  output logic       p2,
  output logic       wait1,
  output logic       wait2
);

  typedef enum logic [2:0] {
    S_G1    = 3'd0,
    S_Y1    = 3'd1,
    S_R1    = 3'd2,
    S_G2    = 3'd3,
    S_Y2    = 3'd4,
    S_R2    = 3'd5,
    S_NIGHT = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_G   = 2'd0;
  localparam logic [1:0] LAMP_Y   = 2'd1;
  localparam logic [1:0] LAMP_R   = 2'd2;
  localparam logic [1:0] LAMP_OFF = 2'd3;

  // Last count value of each phase (a phase of length T spans cnt=0..T-1).
  localparam logic [CW-1:0] GREEN_LAST  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] MINGRN_LAST = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] FLASH_LAST  = CW'(T_FLASH - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend1, pend1_n;
  logic          pend2, pend2_n;
  logic          flash, flash_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_R2;
      cnt   <= '0;
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      flash <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend1 <= pend1_n;
      pend2 <= pend2_n;
      flash <= flash_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    flash_n = flash;
    c1      = LAMP_R;
    c2      = LAMP_R;
    p1      = 1'b0;
    p2      = 1'b0;

    case (state)
      S_G1: begin
        c1 = LAMP_G;
        p1 = 1'b1;
        // Early cut uses the registered request; harmless when cnt is already at the last value.
        if (cnt == GREEN_LAST || (pend2 && cnt >= MINGRN_LAST)) state_n = S_Y1;
      end
      S_Y1: begin
        c1 = LAMP_Y;
        if (cnt == YELLOW_LAST) state_n = S_R1;
      end
      S_R1: begin
        if (cnt == ALLRED_LAST) state_n = night ? S_NIGHT : S_G2;
      end
      S_G2: begin
        c2 = LAMP_G;
        p2 = 1'b1;
        if (cnt == GREEN_LAST || (pend1 && cnt >= MINGRN_LAST)) state_n = S_Y2;
      end
      S_Y2: begin
        c2 = LAMP_Y;
        if (cnt == YELLOW_LAST) state_n = S_R2;
      end
      S_R2: begin
        if (cnt == ALLRED_LAST) state_n = night ? S_NIGHT : S_G1;
      end
      S_NIGHT: begin
        c1 = flash ? LAMP_Y : LAMP_OFF;
        c2 = flash ? LAMP_Y : LAMP_OFF;
        if (!night) begin
          state_n = S_R2;
        end else if (cnt == FLASH_LAST) begin
          flash_n = ~flash;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_R2;
      end
    endcase

    // Every phase change restarts the counter; night always starts dark.
    if (state_n != state) begin
      cnt_n = '0;
      if (state_n == S_NIGHT) flash_n = 1'b0;
    end

    // Requests are dropped while in (or entering) night mode; entering the served
    // green clears the latch even if the button is still held.
    pend1_n = pend1;
    pend2_n = pend2;
    if (state == S_NIGHT || state_n == S_NIGHT) begin
      pend1_n = 1'b0;
      pend2_n = 1'b0;
    end else begin
      if (state_n == S_G1 && state != S_G1) pend1_n = 1'b0;
      else if (ped_req1 && state != S_G1)   pend1_n = 1'b1;
      if (state_n == S_G2 && state != S_G2) pend2_n = 1'b0;
      else if (ped_req2 && state != S_G2)   pend2_n = 1'b1;
    end
  end

  assign wait1 = pend1;
  assign wait2 = pend2;

endmodule

// File: tb/tb_semaforo_ctrl.sv
module tb_semaforo_ctrl;

  localparam int TG = 8, TMG = 3, TY = 3, TA = 2, TF = 4;

  // Phase names of the reference model.
  localparam int P_G1 = 0, P_Y1 = 1, P_R1 = 2, P_G2 = 3, P_Y2 = 4, P_R2 = 5, P_N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       night = 1'b0;
  logic       ped_req1 = 1'b0;
  logic       ped_req2 = 1'b0;
  logic [1:0] c1, c2;
  logic       p1, p2, wait1, wait2;

  int total = 0;
  int bad   = 0;

  semaforo_ctrl dut (
    .clk(clk), .rst(rst), .night(night), .ped_req1(ped_req1), .ped_req2(ped_req2),
    .c1(c1), .c2(c2), .p1(p1), .p2(p2), .wait1(wait1), .wait2(wait2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks which phase is lit and how long it has been lit, from the rules of operation.
  int m_ph = P_R2, m_age = 0, m_nph, m_nage;
  bit m_p1 = 0, m_p2 = 0, m_fl = 0, m_nfl;
  bit started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_ph = P_R2; m_age = 0; m_p1 = 0; m_p2 = 0; m_fl = 0;
    end else begin
      m_nph = m_ph; m_nage = m_age + 1; m_nfl = m_fl;
      if (m_ph == P_G1 && (m_age == TG - 1 || (m_p2 && m_age >= TMG - 1))) m_nph = P_Y1;
      if (m_ph == P_Y1 && m_age == TY - 1) m_nph = P_R1;
      if (m_ph == P_R1 && m_age == TA - 1) m_nph = night ? P_N : P_G2;
      if (m_ph == P_G2 && (m_age == TG - 1 || (m_p1 && m_age >= TMG - 1))) m_nph = P_Y2;
      if (m_ph == P_Y2 && m_age == TY - 1) m_nph = P_R2;
      if (m_ph == P_R2 && m_age == TA - 1) m_nph = night ? P_N : P_G1;
      if (m_ph == P_N) begin
        if (!night) m_nph = P_R2;
        else if (m_age == TF - 1) begin m_nfl = !m_fl; m_nage = 0; end
      end
      if (m_nph != m_ph) begin
        m_nage = 0;
        if (m_nph == P_N) m_nfl = 0;
      end
      if (m_ph == P_N || m_nph == P_N) begin
        m_p1 = 0; m_p2 = 0;
      end else begin
        if (m_nph == P_G1 && m_ph != P_G1) m_p1 = 0;
        else if (ped_req1 && m_ph != P_G1) m_p1 = 1;
        if (m_nph == P_G2 && m_ph != P_G2) m_p2 = 0;
        else if (ped_req2 && m_ph != P_G2) m_p2 = 1;
      end
      m_ph = m_nph; m_age = m_nage; m_fl = m_nfl;
    end
  end

  // Compare process: every cycle after the first edge, all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      int e1, e2, got, exp;
      case (m_ph)
        P_G1:    begin e1 = 0; e2 = 2; end
        P_Y1:    begin e1 = 1; e2 = 2; end
        P_G2:    begin e1 = 2; e2 = 0; end
        P_Y2:    begin e1 = 2; e2 = 1; end
        P_N:     begin e1 = m_fl ? 1 : 3; e2 = e1; end
        default: begin e1 = 2; e2 = 2; end
      endcase
      exp = (e1 << 6) | (e2 << 4) | (int'(m_ph == P_G1) << 3) | (int'(m_ph == P_G2) << 2)
          | (int'(m_p1) << 1) | int'(m_p2);
      got = (int'(c1) << 6) | (int'(c2) << 4) | (int'(p1) << 3) | (int'(p2) << 2)
          | (int'(wait1) << 1) | int'(wait2);
      chk("model{c1,c2,p1,p2,w1,w2}", got, exp);
    end
  end

  // Counts negedges for which the lamps keep the given pair (bounded).
  task automatic run_len(input logic [1:0] a, input logic [1:0] b, output int n);
    n = 0;
    while (c1 == a && c2 == b && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    // Test 1: reset then free run, one full period.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset c1", c1, 2);
    chk("reset wait2", wait2, 0);
    rst = 1'b0;
    run_len(2'd2, 2'd2, n); chk("t1 R2 len", n, 2);
    chk("t1 p1 in G1", p1, 1);
    run_len(2'd0, 2'd2, n); chk("t1 G1 len", n, 8);
    chk("t1 p1 in Y1", p1, 0);
    run_len(2'd1, 2'd2, n); chk("t1 Y1 len", n, 3);
    run_len(2'd2, 2'd2, n); chk("t1 R1 len", n, 2);
    chk("t1 p2 in G2", p2, 1);
    run_len(2'd2, 2'd0, n); chk("t1 G2 len", n, 8);
    run_len(2'd2, 2'd1, n); chk("t1 Y2 len", n, 3);
    run_len(2'd2, 2'd2, n); chk("t1 R2b len", n, 2);

    // Test 2: ped_req2 at G1 cnt=1 -> G1 lasts 3.
    @(negedge clk);                       // G1 cnt=1
    ped_req2 = 1'b1;
    @(negedge clk);                       // G1 cnt=2
    ped_req2 = 1'b0;
    chk("t2 wait2 set", wait2, 1);
    run_len(2'd0, 2'd2, n); chk("t2 G1 len", n + 2, 3);
    run_len(2'd1, 2'd2, n); chk("t2 Y1 len", n, 3);
    chk("t2 wait2 in R1", wait2, 1);
    run_len(2'd2, 2'd2, n);
    chk("t2 wait2 at G2", wait2, 0);
    run_len(2'd2, 2'd0, n); chk("t2 G2 len", n, 8);
    run_len(2'd2, 2'd1, n);
    run_len(2'd2, 2'd2, n);

    // Test 3: ped_req2 at G1 cnt=5 -> G1 lasts 7; ped_req1 during G1 ignored.
    repeat (5) @(negedge clk);            // G1 cnt=5
    ped_req1 = 1'b1; ped_req2 = 1'b1;
    @(negedge clk);
    ped_req1 = 1'b0; ped_req2 = 1'b0;
    chk("t3 wait1 stays 0", wait1, 0);
    run_len(2'd0, 2'd2, n); chk("t3 G1 len", n + 6, 7);
    chk("t3 wait1 in Y1", wait1, 0);
    run_len(2'd1, 2'd2, n);
    run_len(2'd2, 2'd2, n);

    // Test 4: night raised mid-G2.
    repeat (3) @(negedge clk);            // G2 cnt=3
    night = 1'b1;
    run_len(2'd2, 2'd0, n); chk("t4 G2 len", n + 3, 8);
    run_len(2'd2, 2'd1, n); chk("t4 Y2 len", n, 3);
    run_len(2'd2, 2'd2, n); chk("t4 R2 len", n, 2);
    chk("t4 p1 night", p1, 0);
    run_len(2'd3, 2'd3, n); chk("t4 off1", n, 4);
    run_len(2'd1, 2'd1, n); chk("t4 on1", n, 4);
    run_len(2'd3, 2'd3, n); chk("t4 off2", n, 4);
    run_len(2'd1, 2'd1, n); chk("t4 on2", n, 4);
    night = 1'b0;
    @(negedge clk);
    run_len(2'd2, 2'd2, n); chk("t4 R2 after night", n, 2);
    chk("t4 G1 after night", c1, 0);

    // Test 5: button held across R2->G1; buttons in night ignored.
    run_len(2'd0, 2'd2, n);
    run_len(2'd1, 2'd2, n);
    run_len(2'd2, 2'd2, n);
    run_len(2'd2, 2'd0, n);
    run_len(2'd2, 2'd1, n);               // now R2 cnt=0
    ped_req1 = 1'b1;
    @(negedge clk);                       // R2 cnt=1
    chk("t5 wait1 set in R2", wait1, 1);
    @(negedge clk);                       // G1 cnt=0
    chk("t5 wait1 cleared", wait1, 0);
    ped_req1 = 1'b0;
    night = 1'b1;
    run_len(2'd0, 2'd2, n);
    run_len(2'd1, 2'd2, n);
    run_len(2'd2, 2'd2, n);               // NIGHT cnt=0
    chk("t5 night entered", c1, 3);
    ped_req1 = 1'b1; ped_req2 = 1'b1;
    @(negedge clk);
    ped_req1 = 1'b0; ped_req2 = 1'b0;
    chk("t5 wait1 night", wait1, 0);
    chk("t5 wait2 night", wait2, 0);
    @(negedge clk);
    night = 1'b0;
    @(negedge clk);
    run_len(2'd2, 2'd2, n); chk("t5 R2 after night", n, 2);

    // Test 6: reset during Y1 cnt=1 with a request pending.
    run_len(2'd0, 2'd2, n);               // Y1 cnt=0
    ped_req2 = 1'b1;
    @(negedge clk);                       // Y1 cnt=1
    ped_req2 = 1'b0;
    chk("t6 wait2 before rst", wait2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 c1 after rst", c1, 2);
    chk("t6 wait2 after rst", wait2, 0);
    run_len(2'd2, 2'd2, n); chk("t6 R2 len", n, 2);
    run_len(2'd0, 2'd2, n); chk("t6 G1 len", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
